cordic_phase_seq: RTL and testbench

CORDIC_PHASE_SEQ -- requirements
Module: cordic_phase_seq

---
 rtl/cordic_pkg.sv | 17 +
 rtl/valid_delay_line.sv | 28 ++
 rtl/cordic_phase_seq.sv | 109 ++++++++++
 tb/tb_cordic_phase_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared sizing, phase constants and sequencer state type for the CORDIC phase sequencer.
// Holds no logic, so it adds no latency and has no flow-control behaviour.
package cordic_pkg;
  localparam int PHASE_W   = 32;
  localparam int WIDTH     = 16;
  localparam int LATENCY   = 16;
  localparam int AMPLITUDE = 9949;

  // A quarter turn of the phase wheel.
  localparam logic [PHASE_W-1:0] DEG_90 = {2'b01, {(PHASE_W-2){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/valid_delay_line.sv
// Shift register that models the valid bit of the downstream CORDIC pipeline.
// Latency is LATENCY cycles; it always accepts its input, with no backpressure.
module valid_delay_line #(
  parameter int LATENCY = cordic_pkg::LATENCY
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in,
  output logic out
);
  logic [LATENCY-1:0] sr;

  generate
    if (LATENCY == 1) begin : g_one
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= in;
      end
    end else begin : g_many
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sr <= '0;
        else          sr <= {sr[LATENCY-2:0], in};
      end
    end
  endgenerate

  assign out = sr[LATENCY-1];
endmodule

// File: rtl/cordic_phase_seq.sv
// Burst phase-ramp generator that feeds angle and start vectors into a CORDIC rotator.
// Samples are launched the cycle after start; results are tracked LATENCY cycles later; there is no backpressure.
module cordic_phase_seq #(
  parameter int WIDTH     = cordic_pkg::WIDTH,
  parameter int PHASE_W   = cordic_pkg::PHASE_W,
  parameter int LATENCY   = cordic_pkg::LATENCY,
  parameter int AMPLITUDE = cordic_pkg::AMPLITUDE
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [PHASE_W-1:0]        ftw,
  input  logic [PHASE_W-1:0]        phase_offset,
  input  logic [15:0]               num_samples,
  output logic signed [PHASE_W-1:0] angle,
  output logic signed [WIDTH-1:0]   x_start,
  output logic signed [WIDTH-1:0]   y_start,
  output logic                      sample_valid,
  output logic                      result_valid,
  output logic                      busy,
  output logic                      done
);
  import cordic_pkg::*;

  localparam int DW = $clog2(LATENCY + 1);

  state_t             state;
  logic [PHASE_W-1:0] ftw_r;
  logic [PHASE_W-1:0] acc;
  logic [15:0]        num_r;
  logic [15:0]        cnt;
  logic [DW-1:0]      drain_cnt;
  logic               run_end;

  // A zero burst length means the ramp only ends on stop.
  assign run_end = stop || ((num_r != 16'd0) && (cnt == num_r));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ftw_r        <= '0;
      acc          <= '0;
      num_r        <= '0;
      cnt          <= '0;
      drain_cnt    <= '0;
      angle        <= '0;
      x_start      <= '0;
      y_start      <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            ftw_r        <= ftw;
            num_r        <= num_samples;
            // acc always holds the phase of the next sample to issue.
            acc          <= phase_offset + ftw;
            cnt          <= 16'd1;
            angle        <= phase_offset;
            x_start      <= WIDTH'(AMPLITUDE);
            y_start      <= '0;
            sample_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (run_end) begin
            angle        <= '0;
            x_start      <= '0;
            y_start      <= '0;
            sample_valid <= 1'b0;
            drain_cnt    <= DW'(LATENCY - 1);
            state        <= DRAIN;
          end else begin
            angle <= acc;
            acc   <= acc + ftw_r;
            cnt   <= cnt + 16'd1;
          end
        end
        DRAIN: begin
          // done is raised once the final result has left the pipeline; busy holds through that pulse.
          if (done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (drain_cnt == '0) begin
            done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  valid_delay_line #(
    .LATENCY (LATENCY)
  ) u_valid_delay_line (
    .clock   (clock),
    .reset_n (reset_n),
    .in      (sample_valid),
    .out     (result_valid)
  );
endmodule

// File: tb/tb_cordic_phase_seq.sv
// Self-checking bench for cordic_phase_seq: table vectors, reset/ignore corner cases and random bursts.
module tb_cordic_phase_seq;
  localparam int LAT = 16;
  localparam int AMP = 9949;

  logic               clock = 1'b0;
  logic               reset_n = 1'b1;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [31:0]        ftw = '0;
  logic [31:0]        phase_offset = '0;
  logic [15:0]        num_samples = '0;
  logic signed [31:0] angle;
  logic signed [15:0] x_start;
  logic signed [15:0] y_start;
  logic               sample_valid;
  logic               result_valid;
  logic               busy;
  logic               done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] f;
    logic [31:0] o;
    int          n;
    int          stop_k;   // cycle (0 = first sample) in which stop is high, -1 = never
    int          chg_k;    // cycle in which start is re-pulsed and inputs change, -1 = never
    int          exp_n;
    int          exp_busy;
    bit          has_a;
    logic [31:0] a0, a1, a2, a3;
  } vec_t;

  vec_t tab[7];

  cordic_phase_seq #(
    .WIDTH     (16),
    .PHASE_W   (32),
    .LATENCY   (LAT),
    .AMPLITUDE (AMP)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .ftw          (ftw),
    .phase_offset (phase_offset),
    .num_samples  (num_samples),
    .angle        (angle),
    .x_start      (x_start),
    .y_start      (y_start),
    .sample_valid (sample_valid),
    .result_valid (result_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] f, input logic [31:0] o, input int n,
                              input int stop_k, input int chg_k, input int exp_n,
                              input int exp_busy, input bit has_a,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.f = f; v.o = o; v.n = n; v.stop_k = stop_k; v.chg_k = chg_k;
    v.exp_n = exp_n; v.exp_busy = exp_busy; v.has_a = has_a;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    return v;
  endfunction

  // Called just after a rising edge; returns just after a rising edge with the block idle.
  task automatic run_burst(input vec_t v, input string tag);
    int nsamp = 0;
    int nrv = 0;
    int ndone = 0;
    int nbusy = 0;
    int badxy = 0;
    int first_s = -1;
    int last_s = -1;
    int first_rv = -1;
    int last_rv = -1;
    int done_c = -1;
    bit finished = 1'b0;
    logic [31:0] e;
    ftw = v.f;
    phase_offset = v.o;
    num_samples = 16'(v.n);
    start = 1'b1;
    stop = 1'b0;
    @(posedge clock); #1;
    for (int c = 0; c < 300 && !finished; c++) begin
      start = (c == v.chg_k);
      stop = (c == v.stop_k);
      if (c == v.chg_k) begin
        ftw = ~v.f;
        phase_offset = v.o + 32'h0123_4567;
        num_samples = 16'(v.n + 3);
      end
      @(negedge clock);
      if (sample_valid) begin
        e = v.o + 32'(nsamp) * v.f;
        if (v.has_a && nsamp < 4)
          e = (nsamp == 0) ? v.a0 : (nsamp == 1) ? v.a1 : (nsamp == 2) ? v.a2 : v.a3;
        check($sformatf("%s angle[%0d]", tag, nsamp), angle, e);
        if (x_start !== 16'(AMP) || y_start !== 16'sd0) badxy++;
        if (first_s < 0) first_s = c;
        last_s = c;
        nsamp++;
      end else if (angle !== 32'sd0 || x_start !== 16'sd0 || y_start !== 16'sd0) begin
        badxy++;
      end
      if (result_valid) begin
        if (first_rv < 0) first_rv = c;
        last_rv = c;
        nrv++;
      end
      if (done) begin
        ndone++;
        done_c = c;
      end
      if (busy) nbusy++;
      else finished = 1'b1;
      @(posedge clock); #1;
    end
    start = 1'b0;
    stop = 1'b0;
    check({tag, " finished"}, 32'(finished), 32'd1);
    check({tag, " samples"}, nsamp, v.exp_n);
    check({tag, " first_sample_cyc"}, first_s, 0);
    check({tag, " last_sample_cyc"}, last_s, v.exp_n - 1);
    check({tag, " xy_errors"}, badxy, 0);
    check({tag, " results"}, nrv, v.exp_n);
    check({tag, " first_result_cyc"}, first_rv, LAT);
    check({tag, " last_result_cyc"}, last_rv, LAT + v.exp_n - 1);
    check({tag, " done_pulses"}, ndone, 1);
    check({tag, " done_cyc"}, done_c, LAT + v.exp_n);
    check({tag, " busy_cycles"}, nbusy, v.exp_busy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns;
    int nsv;
    int nrv;
    int ndn;
    int nbz;
    vec_t rv;

    tab[0] = mk(32'h1555_5555, 32'h0000_0000, 4, -1, -1, 4, LAT + 5, 1'b1,
                32'h0000_0000, 32'h1555_5555, 32'h2AAA_AAAA, 32'h3FFF_FFFF);
    tab[1] = mk(32'h4000_0000, 32'hC000_0000, 3, -1, -1, 3, LAT + 4, 1'b1,
                32'hC000_0000, 32'h0000_0000, 32'h4000_0000, 32'h0);
    tab[2] = mk(32'h0100_0000, 32'h1234_5678, 0, 9, -1, 10, LAT + 11, 1'b1,
                32'h1234_5678, 32'h1334_5678, 32'h1434_5678, 32'h1534_5678);
    tab[3] = mk(32'h1000_0000, 32'h0000_0000, 5, -1, 2, 5, LAT + 6, 1'b1,
                32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000);
    tab[4] = mk(32'h1111_1111, 32'h4000_0000, 1, -1, -1, 1, 18, 1'b1,
                32'h4000_0000, 32'h0, 32'h0, 32'h0);
    tab[5] = mk(32'h0000_0100, 32'hFFFF_FF00, 6, 5, -1, 6, LAT + 7, 1'b1,
                32'hFFFF_FF00, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200);
    tab[6] = mk(32'h8000_0000, 32'h0000_0001, 20, 2, -1, 3, LAT + 4, 1'b1,
                32'h0000_0001, 32'h8000_0001, 32'h0000_0001, 32'h0);

    #1 reset_n = 1'b0;
    #2;
    check("reset angle", angle, 32'h0);
    check("reset x_start", 32'(x_start), 32'h0);
    check("reset y_start", 32'(y_start), 32'h0);
    check("reset sample_valid", 32'(sample_valid), 32'h0);
    check("reset result_valid", 32'(result_valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // start together with stop must be ignored
    start = 1'b1;
    stop = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("start_with_stop busy[%0d]", i), 32'(busy), 32'h0);
      check($sformatf("start_with_stop valid[%0d]", i), 32'(sample_valid), 32'h0);
    end
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) run_burst(tab[i], $sformatf("vec%0d", i));

    // reset in the middle of a burst discards everything in flight
    ftw = 32'h0100_0000;
    phase_offset = 32'h0;
    num_samples = 16'd8;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    ns = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (sample_valid) ns++;
    end
    check("midreset samples_before", ns, 3);
    #2 reset_n = 1'b0;
    #1;
    check("midreset angle", angle, 32'h0);
    check("midreset x_start", 32'(x_start), 32'h0);
    check("midreset sample_valid", 32'(sample_valid), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    nsv = 0; nrv = 0; ndn = 0; nbz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (sample_valid) nsv++;
      if (result_valid) nrv++;
      if (done) ndn++;
      if (busy) nbz++;
    end
    check("midreset later_samples", nsv, 0);
    check("midreset later_results", nrv, 0);
    check("midreset later_done", ndn, 0);
    check("midreset later_busy", nbz, 0);
    @(posedge clock); #1;
    run_burst(tab[0], "after_reset");

    for (int i = 0; i < 8; i++) begin
      rv.f = $urandom;
      rv.o = $urandom;
      rv.n = int'($urandom_range(0, 12));
      if (rv.n == 0) rv.stop_k = int'($urandom_range(0, 15));
      else rv.stop_k = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1;
      rv.chg_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      if (rv.n == 0) rv.exp_n = rv.stop_k + 1;
      else if (rv.stop_k >= 0 && rv.stop_k + 1 < rv.n) rv.exp_n = rv.stop_k + 1;
      else rv.exp_n = rv.n;
      rv.exp_busy = LAT + rv.exp_n + 1;
      rv.has_a = 1'b0;
      rv.a0 = '0; rv.a1 = '0; rv.a2 = '0; rv.a3 = '0;
      run_burst(rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
